dest_drain_arbiter: RTL and testbench
=====================================

Name: dest_drain_arbiter

Overview:
- Downstream stage of the transmitter. Drains the two destination FIFOs (D0, D1) through their POP_D0/POP_D1 inputs and merges the words into one registered output stream for the sink.
- Arbitration is round-robin. A two-phase pop/capture FSM handles the one-cycle FIFO read latency.
- Also provides per-destination delivered-word counters and a sticky error flag for the FSM/bench.

Parameters:
- DATA_W, 6, word width; bit 4 is the destination bit, bit 5 is the VC bit.
- CNT_W, 8, width of the per-destination saturating counters.
- TIMEOUT, 4, maximum cycles in WAIT without the selected FIFO's VALID before an error is declared.

Ports:
- clk  in  1  clock; all state updates on posedge.
- RESET_L  in  1  asynchronous active-low reset.
- D0_EMPTY  in  1  empty flag of FIFO D0.
- D1_EMPTY  in  1  empty flag of FIFO D1.
- DATA_OUT_D0  in  DATA_W  read data of D0.
- DATA_OUT_D1  in  DATA_W  read data of D1.
- D0_VALID  in  1  D0 read-data valid; arrives one cycle after POP_D0.
- D1_VALID  in  1  D1 read-data valid; arrives one cycle after POP_D1.
- SINK_PAUSE  in  1  sink backpressure; blocks new pops.
- POP_D0  out  1  registered pop to D0.
- POP_D1  out  1  registered pop to D1.
- DATA_OUT  out  DATA_W  merged output word.
- VALID_OUT  out  1  one-cycle qualifier for DATA_OUT.
- DEST_OUT  out  1  source of the current word: 0 = D0, 1 = D1.
- CNT_D0  out  CNT_W  words delivered from D0.
- CNT_D1  out  CNT_W  words delivered from D1.
- ERROR_OUT  out  1  sticky error flag.

Behaviour:
- Reset (RESET_L=0, asynchronous, at any time including mid-transfer):
  - state=IDLE; POP_D0=POP_D1=0; DATA_OUT=0; VALID_OUT=0; DEST_OUT=0; CNT_D0=CNT_D1=0; ERROR_OUT=0; last_grant=1, so D0 wins first.
  - An in-flight pop is abandoned, and a VALID arriving after reset release is ignored while in IDLE.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Condition to leave: SINK_PAUSE=0 and (D0_EMPTY=0 or D1_EMPTY=0).
  - Select sel: if both FIFOs are non-empty, pick the one opposite last_grant; otherwise pick the non-empty one.
  - Next state ISSUE, with POP_sel registered high.
- ISSUE:
  - POP_sel is high for exactly this one cycle; last_grant<=sel; next state WAIT.
  - At most one POP is high in any cycle.
- WAIT:
  - If sel's VALID=1: DATA_OUT<=sel data; DEST_OUT<=sel; VALID_OUT<=1 for one cycle; CNT_sel++; next state IDLE.
  - Otherwise the wait counter increments. When it reaches TIMEOUT: ERROR_OUT<=1, next state IDLE, no output.
- Throughput and latency:
  - One word per 3 cycles maximum (IDLE -> ISSUE -> WAIT).
  - Latency from the IDLE sampling edge to VALID_OUT is 3 edges.
- SINK_PAUSE:
  - Sampled only in IDLE.
  - Asserting it during ISSUE/WAIT does not cancel the in-flight word, which is still delivered.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Any VALID from the non-selected FIFO, or any VALID while in IDLE/ISSUE: ERROR_OUT<=1 and that data is discarded.
- ERROR_OUT is cleared only by reset.
- Simultaneous D0_VALID and D1_VALID in WAIT: the selected one is captured; the other sets ERROR_OUT.

Optional Feature:
- Macro: DEST_CHECK_EN.
- Defined:
  - In WAIT, the captured word's bit 4 must equal sel (D0 expects 0, D1 expects 1).
  - On mismatch: word dropped (VALID_OUT stays 0, counter unchanged), ERROR_OUT<=1, FSM returns to IDLE normally.
- Undefined: no check; every captured word is delivered.

Test Plan:
- Reset mid-WAIT: assert RESET_L=0 asynchronously. All outputs 0 immediately; after release, a stray D0_VALID=1 in IDLE sets ERROR_OUT=1.
- Only D0 non-empty, holding 0x05 then 0x0A (D0 model answers POP with VALID next cycle): DATA_OUT=0x05 then 0x0A, DEST_OUT=0, VALID_OUT pulses 3 cycles apart, CNT_D0=2, CNT_D1=0.
- Both non-empty (D0 holds 0x01,0x02; D1 holds 0x11,0x12): output order 0x01, 0x11, 0x02, 0x12; POP_D0/POP_D1 never high together.
- SINK_PAUSE=1 in IDLE with D1 non-empty: no POP for 10 cycles. SINK_PAUSE=1 raised during WAIT: word 0x13 still emitted, then no further pops.
- D0 model never returns VALID after POP: ERROR_OUT=1 exactly TIMEOUT=4 cycles after entering WAIT, FSM back in IDLE. Separately, 256 D1 words: CNT_D1 saturates at 255.
- With DEST_CHECK_EN, D0 returns 0x10: VALID_OUT stays 0, ERROR_OUT=1, CNT_D0 unchanged. Without the macro, 0x10 is delivered and CNT_D0++.

Source files
------------

// File: rtl/dest_drain_arbiter.sv
// dest_drain_arbiter: round-robin drain of destination FIFOs D0/D1 into one registered output stream
// Ports: clk, RESET_L (async active-low); D0_EMPTY/D1_EMPTY, DATA_OUT_D0/DATA_OUT_D1 and
// D0_VALID/D1_VALID from the FIFOs (VALID one cycle after POP); SINK_PAUSE blocks new pops;
// POP_D0/POP_D1 registered pops; DATA_OUT/VALID_OUT/DEST_OUT merged stream;
// CNT_D0/CNT_D1 saturating delivered-word counters; ERROR_OUT sticky protocol error.
// Option: define DEST_CHECK_EN to drop captured words whose bit 4 disagrees with the source FIFO.
module dest_drain_arbiter #(
   parameter int DATA_W  = 6,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              RESET_L,
   input  logic              D0_EMPTY,
   input  logic              D1_EMPTY,
   input  logic [DATA_W-1:0] DATA_OUT_D0,
   input  logic [DATA_W-1:0] DATA_OUT_D1,
   input  logic              D0_VALID,
   input  logic              D1_VALID,
   input  logic              SINK_PAUSE,
   output logic              POP_D0,
   output logic              POP_D1,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic              VALID_OUT,
   output logic              DEST_OUT,
   output logic [CNT_W-1:0]  CNT_D0,
   output logic [CNT_W-1:0]  CNT_D1,
   output logic              ERROR_OUT
);
   localparam int WW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_n;
   logic sel, last_grant, go, pick, sel_valid, oth_valid, dest_ok, timeout_hit, deliver, err_set;
   logic [DATA_W-1:0] sel_data;
   logic [WW-1:0] wcnt;

   always_ff @(posedge clk or negedge RESET_L)
      if (!RESET_L) state <= IDLE;
      else state <= state_n;

   always_comb begin
      go          = !SINK_PAUSE && !(D0_EMPTY && D1_EMPTY);
      // both ready: alternate away from the last grant; otherwise take whichever has data
      pick        = (!D0_EMPTY && !D1_EMPTY) ? !last_grant : D0_EMPTY;
      sel_valid   = sel ? D1_VALID : D0_VALID;
      oth_valid   = sel ? D0_VALID : D1_VALID;
      sel_data    = sel ? DATA_OUT_D1 : DATA_OUT_D0;
`ifdef DEST_CHECK_EN
      dest_ok     = sel_data[4] == sel;
`else
      dest_ok     = 1'b1;
`endif
      timeout_hit = wcnt == WW'(TIMEOUT - 1);
      deliver     = state == WAIT && sel_valid && dest_ok;
      // outside WAIT any read data is unsolicited; inside WAIT only the selected FIFO may answer
      err_set     = (state != WAIT) ? (D0_VALID || D1_VALID)
                                    : (oth_valid || (sel_valid && !dest_ok) || (!sel_valid && timeout_hit));
      state_n     = (state == IDLE)  ? (go ? ISSUE : IDLE) :
                    (state == ISSUE) ? WAIT :
                    (sel_valid || timeout_hit) ? IDLE : WAIT;
   end

   always_ff @(posedge clk or negedge RESET_L)
      if (!RESET_L) begin
         POP_D0     <= 1'b0;
         POP_D1     <= 1'b0;
         DATA_OUT   <= '0;
         VALID_OUT  <= 1'b0;
         DEST_OUT   <= 1'b0;
         CNT_D0     <= '0;
         CNT_D1     <= '0;
         ERROR_OUT  <= 1'b0;
         sel        <= 1'b0;
         last_grant <= 1'b1;
         wcnt       <= '0;
      end else begin
         POP_D0    <= state == IDLE && go && !pick;
         POP_D1    <= state == IDLE && go && pick;
         VALID_OUT <= deliver;
         if (state == IDLE && go) sel <= pick;
         if (state == ISSUE) last_grant <= sel;
         wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
         if (deliver) begin
            DATA_OUT <= sel_data;
            DEST_OUT <= sel;
         end
         if (deliver && !sel && !(&CNT_D0)) CNT_D0 <= CNT_D0 + 1'b1;
         if (deliver && sel && !(&CNT_D1)) CNT_D1 <= CNT_D1 + 1'b1;
         if (err_set) ERROR_OUT <= 1'b1;
      end
endmodule

// File: tb/tb_dest_drain_arbiter.sv
// tb_dest_drain_arbiter: self-checking bench for dest_drain_arbiter against a behavioural model
module tb_dest_drain_arbiter;
  localparam int DATA_W = 6, CNT_W = 8, TIMEOUT = 4;
  localparam int MAXC = (1 << CNT_W) - 1;
`ifdef DEST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, RESET_L = 1'b0, SINK_PAUSE = 1'b0;
  logic D0_EMPTY, D1_EMPTY, D0_VALID, D1_VALID;
  logic [DATA_W-1:0] DATA_OUT_D0, DATA_OUT_D1, DATA_OUT;
  logic POP_D0, POP_D1, VALID_OUT, DEST_OUT, ERROR_OUT;
  logic [CNT_W-1:0] CNT_D0, CNT_D1;
  dest_drain_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RESET_L(RESET_L), .D0_EMPTY(D0_EMPTY), .D1_EMPTY(D1_EMPTY),
    .DATA_OUT_D0(DATA_OUT_D0), .DATA_OUT_D1(DATA_OUT_D1), .D0_VALID(D0_VALID), .D1_VALID(D1_VALID),
    .SINK_PAUSE(SINK_PAUSE), .POP_D0(POP_D0), .POP_D1(POP_D1), .DATA_OUT(DATA_OUT),
    .VALID_OUT(VALID_OUT), .DEST_OUT(DEST_OUT), .CNT_D0(CNT_D0), .CNT_D1(CNT_D1), .ERROR_OUT(ERROR_OUT));
  initial forever #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // FIFO models: write side owned by the stimulus, read side answers POP one cycle later
  logic [DATA_W-1:0] mem0 [512], mem1 [512];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  logic fv0 = 1'b0, fv1 = 1'b0, mute0 = 1'b0, mute1 = 1'b0, stray0 = 1'b0, stray1 = 1'b0;
  logic [DATA_W-1:0] rd0 = '0, rd1 = '0, sd0 = '0, sd1 = '0;
  assign D0_EMPTY = rp0 >= wp0;
  assign D1_EMPTY = rp1 >= wp1;
  assign D0_VALID = fv0 | stray0;
  assign D1_VALID = fv1 | stray1;
  assign DATA_OUT_D0 = stray0 ? sd0 : rd0;
  assign DATA_OUT_D1 = stray1 ? sd1 : rd1;
  always @(posedge clk) begin
    fv0 <= POP_D0 && !mute0;
    fv1 <= POP_D1 && !mute1;
    if (POP_D0) begin rd0 <= mem0[rp0 % 512]; rp0 <= rp0 + 1; end
    if (POP_D1) begin rd1 <= mem1[rp1 % 512]; rp1 <= rp1 + 1; end
  end
  // behavioural model: m_age < 0 idle, 0 = pop cycle, 1..TIMEOUT = cycles spent waiting for data
  int m_age;
  logic m_g, m_last, m_err, m_valid, m_pop0, m_pop1, m_dest;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0] m_cnt0, m_cnt1;
  always @(posedge clk or negedge RESET_L) begin : mdl
    int age; logic g, last, err, valid, p0, p1, dst, vs, vo; logic [DATA_W-1:0] d, w; logic [CNT_W-1:0] c0, c1;
    if (!RESET_L) begin
      m_age <= -1; m_g <= 1'b0; m_last <= 1'b1; m_err <= 1'b0; m_valid <= 1'b0; m_pop0 <= 1'b0;
      m_pop1 <= 1'b0; m_dest <= 1'b0; m_data <= '0; m_cnt0 <= '0; m_cnt1 <= '0;
    end else begin
      age = m_age; g = m_g; last = m_last; err = m_err; d = m_data; dst = m_dest; c0 = m_cnt0; c1 = m_cnt1;
      valid = 1'b0; p0 = 1'b0; p1 = 1'b0;
      if (age < 0) begin
        if (D0_VALID || D1_VALID) err = 1'b1;
        if (!SINK_PAUSE && !(D0_EMPTY && D1_EMPTY)) begin
          g = (!D0_EMPTY && !D1_EMPTY) ? !last : D0_EMPTY;
          p0 = !g; p1 = g; age = 0;
        end
      end else if (age == 0) begin
        if (D0_VALID || D1_VALID) err = 1'b1;
        last = g; age = 1;
      end else begin
        vs = g ? D1_VALID : D0_VALID;
        vo = g ? D0_VALID : D1_VALID;
        w = g ? DATA_OUT_D1 : DATA_OUT_D0;
        if (vo) err = 1'b1;
        if (vs) begin
          age = -1;
          if (CHK && w[4] != g) err = 1'b1;
          else begin
            valid = 1'b1; d = w; dst = g;
            if (g) c1 = (int'(c1) == MAXC) ? c1 : c1 + 1'b1;
            else c0 = (int'(c0) == MAXC) ? c0 : c0 + 1'b1;
          end
        end else if (age == TIMEOUT) begin
          err = 1'b1; age = -1;
        end else age = age + 1;
      end
      m_age <= age; m_g <= g; m_last <= last; m_err <= err; m_valid <= valid; m_pop0 <= p0;
      m_pop1 <= p1; m_dest <= dst; m_data <= d; m_cnt0 <= c0; m_cnt1 <= c1;
    end
  end
  int n_cmp = 0, n_bad = 0;
  int out_d [$], out_s [$], out_c [$];
  task automatic chk(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("POP_D0", POP_D0, m_pop0);
      chk("POP_D1", POP_D1, m_pop1);
      chk("pop_exclusive", POP_D0 & POP_D1, 0);
      chk("VALID_OUT", VALID_OUT, m_valid);
      chk("DATA_OUT", DATA_OUT, m_data);
      chk("DEST_OUT", DEST_OUT, m_dest);
      chk("CNT_D0", CNT_D0, m_cnt0);
      chk("CNT_D1", CNT_D1, m_cnt1);
      chk("ERROR_OUT", ERROR_OUT, m_err);
      if (VALID_OUT) begin out_d.push_back(DATA_OUT); out_s.push_back(DEST_OUT); out_c.push_back(cyc); end
    end
  endtask
  task automatic push0(input logic [DATA_W-1:0] w); mem0[wp0 % 512] = w; wp0++; endtask
  task automatic push1(input logic [DATA_W-1:0] w); mem1[wp1 % 512] = w; wp1++; endtask
  task automatic do_reset();
    @(negedge clk); RESET_L = 1'b0;
    @(negedge clk); @(negedge clk); RESET_L = 1'b1;
  endtask
  task automatic wait_out(input int target);
    int budget;
    budget = 3 * (target - out_d.size()) + 50;
    for (int i = 0; i < budget && out_d.size() < target; i++) @(negedge clk);
    chk("output_count", out_d.size(), target);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_POP_D0"}, POP_D0, 0); chk({tag, "_POP_D1"}, POP_D1, 0);
    chk({tag, "_DATA_OUT"}, DATA_OUT, 0); chk({tag, "_VALID_OUT"}, VALID_OUT, 0);
    chk({tag, "_DEST_OUT"}, DEST_OUT, 0); chk({tag, "_CNT_D0"}, CNT_D0, 0);
    chk({tag, "_CNT_D1"}, CNT_D1, 0); chk({tag, "_ERROR_OUT"}, ERROR_OUT, 0);
  endtask
  initial begin
    int s, npop;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    RESET_L = 1'b1;
    @(negedge clk);
    check_zero("reset");
    // D0 only
    s = out_d.size();
    push0(6'h05); push0(6'h0A);
    wait_out(s + 2);
    chk("d0_first", out_d[s], 6'h05); chk("d0_second", out_d[s+1], 6'h0A);
    chk("d0_dest0", out_s[s], 0); chk("d0_dest1", out_s[s+1], 0);
    chk("d0_spacing", out_c[s+1] - out_c[s], 3);
    chk("d0_cnt0", CNT_D0, 2); chk("d0_cnt1", CNT_D1, 0); chk("model_cnt0", m_cnt0, 2);
    // both FIFOs, round robin starting at D0
    do_reset();
    s = out_d.size();
    push0(6'h01); push0(6'h02); push1(6'h11); push1(6'h12);
    wait_out(s + 4);
    chk("rr_0", out_d[s], 6'h01); chk("rr_1", out_d[s+1], 6'h11);
    chk("rr_2", out_d[s+2], 6'h02); chk("rr_3", out_d[s+3], 6'h12);
    chk("rr_dest1", out_s[s+1], 1);
    // pause in IDLE, then pause raised during WAIT
    SINK_PAUSE = 1'b1;
    push1(6'h13); push1(6'h14);
    npop = 0;
    repeat (10) begin @(negedge clk); npop += int'(POP_D0 | POP_D1); end
    chk("pause_idle_pops", npop, 0);
    SINK_PAUSE = 1'b0;
    for (int i = 0; i < 20 && !POP_D1; i++) @(negedge clk);
    chk("pause_pop1_seen", POP_D1, 1);
    @(negedge clk);
    SINK_PAUSE = 1'b1;
    @(negedge clk);
    chk("pause_wait_valid", VALID_OUT, 1); chk("pause_wait_data", DATA_OUT, 6'h13);
    npop = 0;
    repeat (10) begin @(negedge clk); npop += int'(POP_D0 | POP_D1); end
    chk("pause_after_pops", npop, 0);
    SINK_PAUSE = 1'b0;
    s = out_d.size();
    wait_out(s + 1);
    chk("pause_drain", out_d[s], 6'h14);
    // asynchronous reset in the middle of WAIT, then an unsolicited VALID in IDLE
    mute0 = 1'b1;
    push0(6'h07);
    for (int i = 0; i < 20 && !POP_D0; i++) @(negedge clk);
    chk("midwait_pop0_seen", POP_D0, 1);
    @(negedge clk); @(negedge clk);
    #2 RESET_L = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk); @(negedge clk);
    RESET_L = 1'b1; mute0 = 1'b0;
    @(negedge clk);
    chk("stray_before", ERROR_OUT, 0);
    stray0 = 1'b1; sd0 = 6'h03;
    @(negedge clk);
    chk("stray_error", ERROR_OUT, 1);
    stray0 = 1'b0;
    // timeout: D0 never answers
    do_reset();
    mute0 = 1'b1;
    push0(6'h09);
    for (int i = 0; i < 20 && !POP_D0; i++) @(negedge clk);
    chk("to_pop0_seen", POP_D0, 1);
    repeat (4) @(negedge clk);
    chk("to_not_yet", ERROR_OUT, 0);
    @(negedge clk);
    chk("to_error", ERROR_OUT, 1);
    mute0 = 1'b0;
    s = out_d.size();
    push0(6'h0B);
    wait_out(s + 1);
    chk("to_recover", out_d[s], 6'h0B);
    // destination bit mismatch from D0
    do_reset();
    s = out_d.size();
    push0(6'h10);
    repeat (8) @(negedge clk);
`ifdef DEST_CHECK_EN
    chk("dest_dropped", out_d.size() - s, 0); chk("dest_err", ERROR_OUT, 1); chk("dest_cnt0", CNT_D0, 0);
`else
    chk("dest_delivered", out_d.size() - s, 1); chk("dest_data", out_d[s], 6'h10);
    chk("dest_cnt0", CNT_D0, 1); chk("dest_err", ERROR_OUT, 0);
`endif
    // counter saturation
    do_reset();
    s = out_d.size();
    for (int i = 0; i < 256; i++) push1(6'h11);
    wait_out(s + 256);
    chk("sat_cnt1", CNT_D1, 255); chk("model_sat_cnt1", m_cnt1, 255);
    // randomized traffic with pauses, silent FIFOs and stray VALIDs
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(2) == 0 && wp0 - rp0 < 64) push0(DATA_W'($urandom_range(63)));
      if ($urandom_range(2) == 0 && wp1 - rp1 < 64) push1(DATA_W'($urandom_range(63)));
      SINK_PAUSE = $urandom_range(5) == 0;
      mute0 = $urandom_range(24) == 0; mute1 = $urandom_range(24) == 0;
      stray0 = $urandom_range(59) == 0; stray1 = $urandom_range(59) == 0;
      sd0 = DATA_W'($urandom_range(63)); sd1 = DATA_W'($urandom_range(63));
    end
    @(negedge clk);
    SINK_PAUSE = 1'b0; mute0 = 1'b0; mute1 = 1'b0; stray0 = 1'b0; stray1 = 1'b0;
    for (int i = 0; i < 600 && !(D0_EMPTY && D1_EMPTY); i++) @(negedge clk);
    chk("random_drained", int'(D0_EMPTY && D1_EMPTY), 1);
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
